// File: rtl/sy_dcache_refill.sv
// sy_dcache_refill: fetches one line from memory into a
// local buffer, then installs data and tag in the victim way.
module sy_dcache_refill #(
  parameter int ADDR_WTH   = 40,
  parameter int IDX_WTH    = 12,
  parameter int LINE_BEATS = 8,
  parameter int WAY_NUM    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        miss_valid_i,
  output logic                        miss_ready_o,
  input  logic [ADDR_WTH-1:0]         miss_addr_i,
  input  logic [WAY_NUM-1:0]          miss_way_en_i,
  input  logic [1:0]                  miss_state_i,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [ADDR_WTH-1:0]         mem_addr_o,
  input  logic                        mem_rvalid_i,
  input  logic [63:0]                 mem_rdata_i,
  output logic                        data_req_o,
  input  logic                        data_gnt_i,
  output logic                        data_we_o,
  output logic [WAY_NUM-1:0]          data_way_en_o,
  output logic [IDX_WTH-1:0]          data_idx_o,
  output logic [63:0]                 data_wdata_o,
  output logic                        tag_req_o,
  input  logic                        tag_gnt_i,
  output logic                        tag_we_o,
  output logic [WAY_NUM-1:0]          tag_way_en_o,
  output logic [IDX_WTH-1:0]          tag_idx_o,
  output logic [ADDR_WTH-IDX_WTH-1:0] tag_wr_tag_o,
  output logic [1:0]                  tag_wr_state_o,
  output logic                        tag_wr_valid_o,
  output logic                        done_o,
  output logic                        aborted_o
);
  localparam int CW  = $clog2(LINE_BEATS);
  localparam int OFF = CW + 3;
  localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, MEM_REQ, MEM_RECV, DATA_WR, TAG_WR, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WTH-1:OFF]   addr_q;
  logic [WAY_NUM-1:0]      way_q;
  logic [1:0]              st_q;
  logic                    abort_q, abort_d;
  logic [CW-1:0]           beat_cnt, wr_cnt;
  logic [63:0]             line_q [LINE_BEATS];
  logic                    unused_addr;

  assign unused_addr = ^miss_addr_i[OFF-1:0];

  // next state, sticky abort and per-state port drive
  always_comb begin
    state_d        = state_q;
    abort_d        = abort_q;
    miss_ready_o   = 1'b0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    data_req_o     = 1'b0;
    data_we_o      = 1'b0;
    data_way_en_o  = '0;
    data_idx_o     = '0;
    data_wdata_o   = '0;
    tag_req_o      = 1'b0;
    tag_we_o       = 1'b0;
    tag_way_en_o   = '0;
    tag_idx_o      = '0;
    tag_wr_tag_o   = '0;
    tag_wr_state_o = '0;
    tag_wr_valid_o = 1'b0;
    done_o         = 1'b0;
    aborted_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        abort_d      = 1'b0;
        if (miss_valid_i) state_d = MEM_REQ;
      end
      MEM_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q, {OFF{1'b0}}};
        if (flush_i) abort_d = 1'b1;
        if (mem_gnt_i) state_d = MEM_RECV;
      end
      MEM_RECV: begin
        if (flush_i) abort_d = 1'b1;
        if (mem_rvalid_i && beat_cnt == LAST)
          state_d = abort_d ? DONE : DATA_WR;
      end
      DATA_WR: begin
        data_req_o    = 1'b1;
        data_we_o     = 1'b1;
        data_way_en_o = way_q;
        data_idx_o    = {addr_q[IDX_WTH-1:OFF], wr_cnt, 3'b000};
        data_wdata_o  = line_q[wr_cnt];
        if (flush_i) abort_d = 1'b1;
        if (data_gnt_i) begin
          if (abort_d) state_d = DONE;
          else if (wr_cnt == LAST) state_d = TAG_WR;
        end
      end
      TAG_WR: begin
        tag_req_o      = 1'b1;
        tag_we_o       = 1'b1;
        tag_way_en_o   = way_q;
        tag_idx_o      = {addr_q[IDX_WTH-1:OFF], {OFF{1'b0}}};
        tag_wr_tag_o   = addr_q[ADDR_WTH-1:IDX_WTH];
        tag_wr_state_o = st_q;
        tag_wr_valid_o = 1'b1;
        if (tag_gnt_i) begin
          state_d = DONE;
        end else if (flush_i) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        aborted_o = abort_q;
        abort_d   = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, request fields and beat counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      way_q    <= '0;
      st_q     <= '0;
      beat_cnt <= '0;
      wr_cnt   <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (state_q == IDLE && miss_valid_i) begin
        addr_q <= miss_addr_i[ADDR_WTH-1:OFF];
        way_q  <= miss_way_en_i;
        st_q   <= miss_state_i;
      end
      if (state_q == MEM_REQ && mem_gnt_i)
        beat_cnt <= '0;
      else if (state_q == MEM_RECV && mem_rvalid_i)
        beat_cnt <= beat_cnt + CW'(1);
      if (state_q == MEM_RECV)
        wr_cnt <= '0;
      else if (state_q == DATA_WR && data_gnt_i)
        wr_cnt <= wr_cnt + CW'(1);
    end
  end

  // line buffer, captured beat by beat, never reset
  always_ff @(posedge clk_i) begin
    if (state_q == MEM_RECV && mem_rvalid_i)
      line_q[beat_cnt] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_sy_dcache_refill.sv
// tb_sy_dcache_refill: random and directed refills checked
// against a transaction-level model of the refill rules.
module tb_sy_dcache_refill;
  localparam int AW = 40;
  localparam int IW = 12;
  localparam int NB = 8;
  localparam int NW = 4;
  localparam int TW = AW - IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          miss_valid_i;
  logic          miss_ready_o;
  logic [AW-1:0] miss_addr_i;
  logic [NW-1:0] miss_way_en_i;
  logic [1:0]    miss_state_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rvalid_i;
  logic [63:0]   mem_rdata_i;
  logic          data_req_o;
  logic          data_gnt_i;
  logic          data_we_o;
  logic [NW-1:0] data_way_en_o;
  logic [IW-1:0] data_idx_o;
  logic [63:0]   data_wdata_o;
  logic          tag_req_o;
  logic          tag_gnt_i;
  logic          tag_we_o;
  logic [NW-1:0] tag_way_en_o;
  logic [IW-1:0] tag_idx_o;
  logic [TW-1:0] tag_wr_tag_o;
  logic [1:0]    tag_wr_state_o;
  logic          tag_wr_valid_o;
  logic          done_o;
  logic          aborted_o;

  sy_dcache_refill #(
    .ADDR_WTH(AW), .IDX_WTH(IW),
    .LINE_BEATS(NB), .WAY_NUM(NW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i),
    .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr_i),
    .miss_way_en_i(miss_way_en_i),
    .miss_state_i(miss_state_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_we_o(data_we_o),
    .data_way_en_o(data_way_en_o),
    .data_idx_o(data_idx_o),
    .data_wdata_o(data_wdata_o),
    .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i),
    .tag_we_o(tag_we_o),
    .tag_way_en_o(tag_way_en_o),
    .tag_idx_o(tag_idx_o),
    .tag_wr_tag_o(tag_wr_tag_o),
    .tag_wr_state_o(tag_wr_state_o),
    .tag_wr_valid_o(tag_wr_valid_o),
    .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // free-running cycle count for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  bit  cfg_rand = 0;
  bit  cfg_junk = 0;
  bit  cfg_hold_tag = 0;
  int  cfg_gap = 0;
  int  cfg_stall = 0;
  int  t_base = 19;
  bit  t_abort = 0;
  int  t_nd = NB;
  int  t_nt = 1;
  bit  t_noreq = 0;

  logic [63:0] line_m [NB];
  int          gap_total = 0;
  int          drv_idx = 0;
  bit          drv_on = 0;

  int            n_acc = 0;
  int            n_done = 0;
  int            last_lat = 0;
  int            last_done_cyc = 0;
  int            acc_gap = 0;
  logic [IW-1:0] first_idx = '0;
  logic [IW-1:0] last_idx = '0;
  logic [TW-1:0] last_tag = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  // memory and array responder
  initial begin : resp
    bit mem_hs, data_hs;
    int left, gapl, nd_g, stl;
    mem_hs = 0; data_hs = 0;
    left = 0; gapl = 0; nd_g = 0; stl = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0;
    mem_rdata_i = '0; data_gnt_i = 0; tag_gnt_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (data_hs) nd_g++;
      if (mem_hs) begin
        left = NB; gapl = 0;
        nd_g = 0; stl = cfg_stall;
      end
      drv_on = 0;
      if (left > 0 && gapl == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = {$urandom, $urandom};
        drv_idx = NB - left;
        line_m[drv_idx] = mem_rdata_i;
        left--;
        gapl = cfg_gap;
        drv_on = 1;
      end else begin
        if (left > 0) begin
          gapl--;
          gap_total++;
        end
        mem_rvalid_i = (left == 0) && cfg_junk &&
                       ($urandom_range(0, 3) == 0);
        mem_rdata_i = {$urandom, $urandom};
      end
      mem_gnt_i = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (data_req_o && nd_g == 4 && stl > 0) begin
        data_gnt_i = 1'b0;
        stl--;
      end else begin
        data_gnt_i = cfg_rand ?
                     ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (cfg_hold_tag) tag_gnt_i = 1'b0;
      else tag_gnt_i = cfg_rand ?
                       ($urandom_range(0, 3) != 0) : 1'b1;
      mem_hs = mem_req_o && mem_gnt_i;
      data_hs = data_req_o && data_gnt_i;
    end
  end

  // compare process: transaction model checked every cycle
  initial begin : cmp
    logic [AW-1:0] ca;
    logic [NW-1:0] cw;
    logic [1:0]    cs;
    logic [IW-1:0] pidx, eidx;
    logic [63:0]   pdat;
    logic [NW-1:0] pway;
    int  cbase, cnd, cnt_exp, cnt_d, cnt_t, acc, s_cnt, g0;
    bit  cab, cnoreq, active, pstall;
    logic any;
    active = 0; pstall = 0; ca = '0; cw = '0; cs = '0;
    cbase = 0; cnd = 0; cnt_exp = 0; cnt_d = 0; cnt_t = 0;
    acc = 0; s_cnt = 0; g0 = 0; cab = 0; cnoreq = 0;
    pidx = '0; pdat = '0; pway = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        pstall = 0;
        any = mem_req_o | (|mem_addr_o) | data_req_o |
              data_we_o | (|data_way_en_o) | (|data_idx_o) |
              (|data_wdata_o) | tag_req_o | tag_we_o |
              (|tag_way_en_o) | (|tag_idx_o) |
              (|tag_wr_tag_o) | (|tag_wr_state_o) |
              tag_wr_valid_o | done_o | aborted_o;
        chk("rst_ready", miss_ready_o, 1);
        chk("rst_outs", any, 0);
      end else begin
        chk("ready", miss_ready_o, !active);
        chk("excl", data_req_o & tag_req_o, 0);
        chk("abort_qual", aborted_o & ~done_o, 0);
        if (!active) begin
          chk("idle_quiet",
              mem_req_o | data_req_o | tag_req_o | done_o, 0);
        end else begin
          if (cnoreq) chk("no_req", data_req_o | tag_req_o, 0);
          if (mem_req_o)
            chk("mem_addr", mem_addr_o, ca & ~40'h3F);
          if ((mem_req_o && !mem_gnt_i) ||
              (data_req_o && !data_gnt_i) ||
              (tag_req_o && !tag_gnt_i))
            s_cnt++;
          if (data_req_o) begin
            if (pstall) begin
              chk("hold_idx", data_idx_o, pidx);
              chk("hold_dat", data_wdata_o, pdat);
              chk("hold_way", data_way_en_o, pway);
            end
            chk("data_we", data_we_o, 1);
            if (data_gnt_i) begin
              chk("data_allowed", cnt_d < cnd, 1);
              if (cnt_d < NB) begin
                eidx = (ca[IW-1:0] & 12'hFC0) | IW'(cnt_d * 8);
                chk("data_idx", data_idx_o, eidx);
                chk("data_way", data_way_en_o, cw);
                chk("data_wdata", data_wdata_o, line_m[cnt_d]);
              end
              if (cnt_d == 0) first_idx = data_idx_o;
              last_idx = data_idx_o;
              cnt_d++;
            end
          end
          pstall = data_req_o && !data_gnt_i;
          pidx = data_idx_o;
          pdat = data_wdata_o;
          pway = data_way_en_o;
          if (tag_req_o) begin
            chk("tag_order", cnt_d, cnd);
            chk("tag_we", tag_we_o, 1);
            chk("tag_way", tag_way_en_o, cw);
            chk("tag_idx", tag_idx_o, ca[IW-1:0] & 12'hFC0);
            chk("tag_tag", tag_wr_tag_o, ca[AW-1:IW]);
            chk("tag_state", tag_wr_state_o, cs);
            chk("tag_valid", tag_wr_valid_o, 1);
            if (tag_gnt_i) begin
              chk("tag_allowed", cnt_t < cnt_exp, 1);
              last_tag = tag_wr_tag_o;
              cnt_t++;
            end
          end
          if (done_o) begin
            chk("done_cyc", cyc,
                acc + cbase + s_cnt + (gap_total - g0));
            chk("aborted", aborted_o, cab);
            chk("n_data", cnt_d, cnd);
            chk("n_tag", cnt_t, cnt_exp);
            last_lat = cyc - acc;
            last_done_cyc = cyc;
            n_done++;
            active = 0;
          end
        end
        if (miss_valid_i && miss_ready_o) begin
          active = 1;
          acc = cyc;
          acc_gap = cyc - last_done_cyc;
          ca = miss_addr_i;
          cw = miss_way_en_i;
          cs = miss_state_i;
          cbase = t_base;
          cab = t_abort;
          cnd = t_nd;
          cnt_exp = t_nt;
          cnoreq = t_noreq;
          cnt_d = 0;
          cnt_t = 0;
          s_cnt = 0;
          g0 = gap_total;
          pstall = 0;
          n_acc++;
        end
      end
    end
  end

  task automatic set_t(input int base, input bit ab,
                       input int nd, input int nt,
                       input bit noreq);
    t_base = base; t_abort = ab;
    t_nd = nd; t_nt = nt; t_noreq = noreq;
  endtask

  task automatic issue(input logic [AW-1:0] a,
                       input logic [NW-1:0] w,
                       input logic [1:0] s,
                       input bit hold);
    int n0;
    n0 = n_acc;
    miss_addr_i = a;
    miss_way_en_i = w;
    miss_state_i = s;
    miss_valid_i = 1'b1;
    for (int i = 0; i < 200 && n_acc == n0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("accept", n_acc - n0, 1);
    if (!hold) miss_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 400 && n_done <= n0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("done_seen", n_done > n0, 1);
  endtask

  task automatic wait_tag_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = tag_req_o;
    end
    chk("see_tag_req", ok, 1);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[AW-1:0];
  endfunction

  // directed scenarios followed by a random run
  initial begin : main
    int nd0;
    bit ok;
    rst = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0;
    miss_addr_i = '0; miss_way_en_i = '0; miss_state_i = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;

    set_t(19, 0, NB, 1, 0);
    nd0 = n_done;
    issue(40'h01_2345_6780, 4'b0010, 2'b11, 0);
    wait_done(nd0);
    chk("nom_lat", last_lat, 19);
    chk("nom_idx0", first_idx, 12'h780);
    chk("nom_idx7", last_idx, 12'h7B8);
    chk("nom_tag", last_tag, 28'h0123456);

    cfg_stall = 3;
    nd0 = n_done;
    issue(rnd_addr(), 4'b0100, 2'b01, 0);
    wait_done(nd0);
    chk("stall_lat", last_lat, 22);
    cfg_stall = 0;

    cfg_gap = 2;
    nd0 = n_done;
    issue(rnd_addr(), 4'b1000, 2'b10, 0);
    wait_done(nd0);
    chk("gap_lat", last_lat, 33);
    cfg_gap = 0;

    set_t(10, 1, 0, 0, 1);
    nd0 = n_done;
    issue(rnd_addr(), 4'b0001, 2'b11, 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = drv_on && drv_idx == 3;
    end
    chk("see_beat3", ok, 1);
    flush_i = 1'b1;
    @(posedge clk);
    #2;
    flush_i = 1'b0;
    wait_done(nd0);
    chk("flush_lat", last_lat, 10);

    set_t(19, 0, NB, 1, 0);
    nd0 = n_done;
    flush_i = 1'b1;
    issue(rnd_addr(), 4'b0010, 2'b01, 0);
    flush_i = 1'b0;
    wait_done(nd0);

    cfg_hold_tag = 1;
    set_t(18, 1, NB, 0, 0);
    nd0 = n_done;
    issue(rnd_addr(), 4'b0100, 2'b10, 0);
    wait_tag_req(ok);
    flush_i = 1'b1;
    @(posedge clk);
    #2;
    flush_i = 1'b0;
    cfg_hold_tag = 0;
    wait_done(nd0);
    chk("tagflush_lat", last_lat, 19);

    set_t(19, 0, NB, 1, 0);
    nd0 = n_done;
    issue(rnd_addr(), 4'b1000, 2'b11, 0);
    wait_tag_req(ok);
    flush_i = 1'b1;
    @(posedge clk);
    #2;
    flush_i = 1'b0;
    wait_done(nd0);

    nd0 = n_done;
    issue(rnd_addr(), 4'b0001, 2'b01, 0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #2;
      ok = data_req_o;
    end
    chk("see_data_req", ok, 1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("rst_no_done", n_done, nd0);

    nd0 = n_done;
    issue(rnd_addr(), 4'b0010, 2'b10, 1);
    issue(rnd_addr(), 4'b0100, 2'b01, 0);
    chk("b2b_gap", acc_gap, 1);
    wait_done(nd0 + 1);

    cfg_rand = 1;
    cfg_junk = 1;
    for (int k = 0; k < 20; k++) begin
      cfg_gap = $urandom_range(0, 2);
      nd0 = n_done;
      issue(rnd_addr(), NW'(1 << $urandom_range(0, NW - 1)),
            2'($urandom_range(0, 3)), 0);
      wait_done(nd0);
    end
    cfg_rand = 0;
    cfg_junk = 0;
    cfg_gap = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard stop if the run ever wedges
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
